// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: shift-mode codes and FSM state
// encodings used by both the top level and the per-cycle shift cell.
package iter_shifter_pkg;

  typedef logic [1:0] shiftMode_t;
  typedef logic [1:0] fsmState_t;

  localparam shiftMode_t SH_SLL = 2'b00;
  localparam shiftMode_t SH_SRL = 2'b01;
  localparam shiftMode_t SH_SRA = 2'b10;
  localparam shiftMode_t SH_ROL = 2'b11;

  localparam fsmState_t ST_IDLE  = 2'b00;
  localparam fsmState_t ST_SHIFT = 2'b01;
  localparam fsmState_t ST_DONE  = 2'b10;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One iteration of the shifter: moves the accumulator by k (0..STEP) bit
// positions under the selected mode. For STEP=1 this collapses to the classic
// shift-by-one cell.
module iter_shifter_shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]           acc_i,
  input  logic [$clog2(STEP+1)-1:0]  k_i,
  input  logic [1:0]                 mode_i,
  input  logic                       fill_i,
  output logic [WIDTH-1:0]           shifted_o
);

  localparam int RW = $clog2(WIDTH) + 1;

  logic [RW-1:0]    rotBack;
  logic [WIDTH-1:0] fillMask;

  // A rotate by k is the left shift OR'd with the bits that fall off the top.
  // A right shift by WIDTH yields zero, so k=0 rotates correctly.
  assign rotBack  = RW'(WIDTH) - RW'(k_i);
  // Ones in the top k positions, where SRA must insert the latched sign.
  assign fillMask = ~({WIDTH{1'b1}} >> k_i);

  // Select the shifted operand for the current mode.
  always_comb begin
    shifted_o = acc_i;
    case (mode_i)
      SH_SLL:  shifted_o = acc_i << k_i;
      SH_SRL:  shifted_o = acc_i >> k_i;
      SH_SRA:  shifted_o = (acc_i >> k_i) | (fillMask & {WIDTH{fill_i}});
      default: shifted_o = (acc_i << k_i) | (acc_i >> rotBack);
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: accepts an operand through a start/ready handshake,
// shifts it by up to STEP bits per cycle, then pulses done for one cycle with
// a registered result that holds until it is next overwritten.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int KW = $clog2(STEP + 1);
  localparam int CW = (SHAMT_W > KW) ? SHAMT_W : KW;

  fsmState_t          state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [CW-1:0]      remExt;
  logic [CW-1:0]      stepExt;
  logic [CW-1:0]      kExt;
  logic [KW-1:0]      kSel;
  logic [SHAMT_W-1:0] kRem;
  logic [WIDTH-1:0]   stepOut;

  // The per-cycle amount is min(rem, STEP). Compared at a common width because
  // STEP may equal WIDTH, which does not fit in a shift-amount field.
  assign remExt  = CW'(rem_q);
  assign stepExt = CW'(STEP);
  assign kExt    = (remExt < stepExt) ? remExt : stepExt;
  assign kSel    = kExt[KW-1:0];
  assign kRem    = kExt[SHAMT_W-1:0];

  iter_shifter_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc_i     (acc_q),
    .k_i       (kSel),
    .mode_i    (mode_q),
    .fill_i    (fill_q),
    .shifted_o (stepOut)
  );

  // Next-state logic: latch the request, iterate the shift, then report done.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d  = data_in;
          rem_d  = shamt;
          mode_d = mode;
          fill_d = (mode == SH_SRA) & data_in[WIDTH-1];
          if (shamt == '0) begin
            result_d = data_in;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = stepOut;
        rem_d = rem_q - kRem;
        if (rem_q == kRem) begin
          result_d = stepOut;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      mode_q   <= SH_SLL;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: one STEP=1 and one STEP=4 instance share operands
// and are checked cycle by cycle against an arithmetic reference model.
module tb_iter_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] dataIn;
  logic        ready1, busy1, done1;
  logic        ready4, busy4, done4;
  logic [31:0] result1, result4;

  int passed = 0;
  int total  = 0;

  iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .start   (start1),
    .mode    (mode),
    .shamt   (shamt),
    .data_in (dataIn),
    .ready   (ready1),
    .busy    (busy1),
    .done    (done1),
    .result  (result1)
  );

  iter_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .start   (start4),
    .mode    (mode),
    .shamt   (shamt),
    .data_in (dataIn),
    .ready   (ready4),
    .busy    (busy4),
    .done    (done4),
    .result  (result4)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [31:0] refShift(input logic [1:0] m, input int s, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (m)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = $signed(d) >>> s;
      default: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
    endcase
    return r;
  endfunction

  // Launch one operation on both instances and follow it to completion.
  // With glitch set, stray start pulses carrying junk operands are sent to any
  // instance that is still in SHIFT or DONE; they must have no effect.
  task automatic applyStimulus(input logic [1:0] m, input logic [4:0] s,
                               input logic [31:0] d, input logic [31:0] exp,
                               input bit glitch);
    int c1, c4;
    c1 = int'(s);
    c4 = (int'(s) + 3) / 4;
    @(negedge clock);
    checkBit("ready1 idle", ready1, 1'b1);
    checkBit("ready4 idle", ready4, 1'b1);
    mode = m; shamt = s; dataIn = d;
    start1 = 1'b1; start4 = 1'b1;
    for (int n = 1; n <= c1 + 1; n++) begin
      @(negedge clock);
      start1 = 1'b0; start4 = 1'b0;
      checkBit("done1 timing", done1, n == c1 + 1);
      checkBit("busy1 timing", busy1, n <= c1);
      checkBit("ready1 timing", ready1, 1'b0);
      checkBit("done4 timing", done4, n == c4 + 1);
      checkBit("busy4 timing", busy4, n <= c4);
      checkBit("ready4 timing", ready4, n > c4 + 1);
      if (n == c1 + 1) checkOutput("result1", result1, exp);
      if (n >= c4 + 1) checkOutput("result4", result4, exp);
      if (glitch && ($urandom_range(1, 0) == 1)) begin
        mode = 2'($urandom); shamt = 5'($urandom); dataIn = $urandom;
        start1 = (n <= c1 + 1);
        start4 = (n <= c4 + 1);
      end
    end
    @(negedge clock);
    start1 = 1'b0; start4 = 1'b0;
    checkBit("ready1 after", ready1, 1'b1);
    checkBit("busy1 after", busy1, 1'b0);
    checkBit("done1 after", done1, 1'b0);
    checkOutput("result1 held", result1, exp);
    checkBit("ready4 after", ready4, 1'b1);
    checkOutput("result4 held", result4, exp);
  endtask

  // Directed cases first, then reset scenarios, then randomized operations.
  initial begin
    logic [1:0]  m;
    logic [4:0]  s;
    logic [31:0] d;
    bit          sawDone;

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    mode = 2'b00; shamt = 5'd0; dataIn = 32'h0;
    repeat (2) @(negedge clock);
    checkBit("reset ready1", ready1, 1'b1);
    checkBit("reset busy1", busy1, 1'b0);
    checkBit("reset done1", done1, 1'b0);
    checkOutput("reset result1", result1, 32'h0);
    checkBit("reset ready4", ready4, 1'b1);
    checkOutput("reset result4", result4, 32'h0);
    reset = 1'b0;

    applyStimulus(2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b1);
    applyStimulus(2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000, 1'b1);
    applyStimulus(2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000, 1'b0);
    applyStimulus(2'b11, 5'd1,  32'h8000_0001, 32'h0000_0003, 1'b1);
    applyStimulus(2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(2'b01, 5'd7,  32'hF000_0000, 32'h01E0_0000, 1'b1);
    applyStimulus(2'b11, 5'd31, 32'h8000_0001, 32'hC000_0000, 1'b1);

    // Reset during the third SHIFT cycle aborts and clears the result.
    @(negedge clock);
    mode = 2'b00; shamt = 5'd20; dataIn = 32'h1234_5678;
    start1 = 1'b1; start4 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; start4 = 1'b0;
    repeat (2) @(negedge clock);
    checkBit("pre-reset busy1", busy1, 1'b1);
    checkBit("pre-reset busy4", busy4, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkBit("abort ready1", ready1, 1'b1);
    checkBit("abort busy1", busy1, 1'b0);
    checkBit("abort done1", done1, 1'b0);
    checkOutput("abort result1", result1, 32'h0);
    checkBit("abort ready4", ready4, 1'b1);
    checkOutput("abort result4", result4, 32'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done1 || done4 || !ready1 || !ready4) sawDone = 1'b1;
    end
    checkBit("no activity after abort", sawDone, 1'b0);

    // Start coinciding with reset is dropped.
    @(negedge clock);
    reset = 1'b1; start1 = 1'b1; start4 = 1'b1;
    mode = 2'b01; shamt = 5'd5; dataIn = 32'hFFFF_FFFF;
    @(negedge clock);
    reset = 1'b0; start1 = 1'b0; start4 = 1'b0;
    @(negedge clock);
    checkBit("reset-wins ready1", ready1, 1'b1);
    checkBit("reset-wins busy1", busy1, 1'b0);
    checkBit("reset-wins busy4", busy4, 1'b0);
    checkOutput("reset-wins result1", result1, 32'h0);

    for (int t = 0; t < 24; t++) begin
      m = 2'($urandom);
      s = 5'($urandom);
      d = $urandom;
      applyStimulus(m, s, d, refShift(m, int'(s), d), t[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
